mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one behavioural memory port (separate read and write address, 1-cycle registered read data, write on `wren`) between the core's instruction-fetch requester (I) and load/store requester (D). It lets the core run from a unified instruction+data memory instead of two memories. Per-requester valid/ready request handshakes are converted into memory-port cycles, read data is routed back to the requester that issued the read, and round-robin arbitration applies on conflicts. It sits between `core` and a single `mem` instance on the testbench top.

## Interface
- `ADDRWIDTH`, 32, address width passed unchanged to memory (word index)
- `BUSWIDTH`, 32, data width
- `clk` input 1 — single clock, all state on rising edge
- `cpu_rst` input 1 — synchronous, active-high reset
- `i_req_valid`, `d_req_valid` input 1 — request present
- `i_req_we`, `d_req_we` input 1 — 1 = write, 0 = read
- `i_req_addr`, `d_req_addr` input ADDRWIDTH — word address
- `i_req_wdata`, `d_req_wdata` input BUSWIDTH — write data
- `i_req_ready`, `d_req_ready` output 1 — grant; request accepted this cycle when valid&ready
- `i_rsp_valid`, `d_rsp_valid` output 1 — read data valid, one-cycle pulse
- `i_rsp_data`, `d_rsp_data` output BUSWIDTH — read data
- `mem_rd_addr` output ADDRWIDTH, `mem_wr_addr` output ADDRWIDTH, `mem_wr_data` output BUSWIDTH, `mem_wren` output 1 — to memory
- `mem_rd_data` input BUSWIDTH — from memory, valid the cycle after `mem_rd_addr`

## Operation
- Grant logic is combinational from the current request inputs and registered `last_grant` (1 bit: 0=I, 1=D).
- One memory read and one memory write per cycle.
- Only one requester valid: it is granted.
- Both valid, one read and one write: both granted the same cycle (no conflict).
- Both valid, same type (both reads or both writes): the requester not equal to `last_grant` wins. The loser's ready = 0.
- `last_grant` updates only on a conflict cycle, to the winner. Non-conflict grants leave it unchanged.
- Granted read: `mem_rd_addr` = its addr. Register `rd_owner` and `rd_pending` = 1.
- Granted write: `mem_wren` = 1, `mem_wr_addr`/`mem_wr_data` = its addr/data. Writes produce no response.
- No granted read: `mem_rd_addr` = 0. No granted write: `mem_wren` = 0, `mem_wr_addr` = 0, `mem_wr_data` = 0.
- Response cycle (cycle after a granted read): `rd_pending` = 1. The owner's `rsp_valid` = 1 and its `rsp_data` = `mem_rd_data`. The other requester's `rsp_valid` = 0.
- `rsp_data` of a requester with `rsp_valid` = 0 is 0 (masked).
- Requesters hold valid/we/addr/wdata stable until ready. The block does not latch unaccepted requests.
- Read and write to the same address in the same cycle: the read returns the old (pre-write) data. This is a documented, required behaviour.
- No backpressure on responses: requesters always accept `rsp_valid`.

## Timing
- Reset (`cpu_rst` = 1 at a rising edge):
  - `last_grant` = 0 (I), so D wins the first same-type conflict.
  - `rd_pending` = 0, `rd_owner` = 0.
- Outputs during reset and the first cycle after it:
  - `i_rsp_valid` = `d_rsp_valid` = 0.
  - `*_rsp_data` = 0.
  - ready/mem outputs follow the combinational rules. While `cpu_rst` is asserted, both readies are forced to 0 and `mem_wren` = 0.
- Reset mid-operation: an in-flight read's response is dropped (no `rsp_valid` after reset). A write presented while `cpu_rst` = 1 is not performed.
- Grant latency: 0 cycles (ready in the same cycle as valid when uncontended).
- Read latency: `rsp_valid` exactly 1 cycle after the accepting edge.
- Write: memory is updated at the accepting edge.
- Throughput: one read and one write per cycle, sustained, back-to-back, with no bubbles.
- Fairness: under continuous same-type contention, grants alternate I, D, I, D… A requester waits at most 1 cycle.

## Test plan
- Single read: preload mem[5] = 0xDEADBEEF. I reads addr 5 in cycle N.
  - Required: `i_req_ready` = 1 in N.
  - Required: `i_rsp_valid` = 1 with data 0xDEADBEEF in N+1.
  - Required: `d_rsp_valid` = 0 throughout.
- Read + write in parallel: in one cycle, D writes 0x12345678 to addr 9 and I reads addr 9 (old value 0xAAAA0000).
  - Required: both ready = 1 in that cycle.
  - Required: I receives 0xAAAA0000 next cycle.
  - Required: a subsequent I read of addr 9 returns 0x12345678.
- Read contention: I and D read addr 1 and addr 2 continuously for 6 cycles after reset, with mem[1] = 0x11 and mem[2] = 0x22.
  - Required grant order: D, I, D, I, D, I.
  - Required: each `rsp_valid` arrives one cycle after its grant with the correct data, and the responses never cross over between requesters.
- Write contention: both write different addrs in the same cycle.
  - Required: only the non-`last_grant` requester is written that cycle. The other is written the next cycle.
  - Required: memory ends holding both values.
- Reset mid-read: grant a D read in cycle N and assert `cpu_rst` in N+1.
  - Required: `d_rsp_valid` = 0 in N+1 and N+2.
  - Required: the next conflict after reset goes to D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one memory port between the instruction-fetch requester (I) and
//   the load/store requester (D). The memory has separate read and write
//   addresses, so a read and a write can be serviced in the same cycle.
//   Only two reads, or two writes, presented together form a conflict.
//   Conflicts are settled round-robin.
//   Read data comes back one cycle after the accepting edge. It is steered
//   to whichever requester issued the read.
//
// Ports:
//   clk, cpu_rst                  - clock, synchronous active-high reset
//   i_req_* / d_req_*             - valid, we, addr, wdata request inputs
//   i_req_ready / d_req_ready     - combinational grant for this cycle
//   i_rsp_valid / d_rsp_valid     - one-cycle read response pulse
//   i_rsp_data / d_rsp_data       - read data, zero when not valid
//   mem_rd_addr                   - memory read address
//   mem_wr_addr, mem_wr_data,
//   mem_wren                      - memory write port
//   mem_rd_data                   - registered read data from memory
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDRWIDTH = 32,
    parameter int BUSWIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 cpu_rst,

    input  logic                 i_req_valid,
    input  logic                 i_req_we,
    input  logic [ADDRWIDTH-1:0] i_req_addr,
    input  logic [BUSWIDTH-1:0]  i_req_wdata,
    output logic                 i_req_ready,
    output logic                 i_rsp_valid,
    output logic [BUSWIDTH-1:0]  i_rsp_data,

    input  logic                 d_req_valid,
    input  logic                 d_req_we,
    input  logic [ADDRWIDTH-1:0] d_req_addr,
    input  logic [BUSWIDTH-1:0]  d_req_wdata,
    output logic                 d_req_ready,
    output logic                 d_rsp_valid,
    output logic [BUSWIDTH-1:0]  d_rsp_data,

    output logic [ADDRWIDTH-1:0] mem_rd_addr,
    output logic [ADDRWIDTH-1:0] mem_wr_addr,
    output logic [BUSWIDTH-1:0]  mem_wr_data,
    output logic                 mem_wren,
    input  logic [BUSWIDTH-1:0]  mem_rd_data
);

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic last_grant;
    logic rd_pending;
    logic rd_owner;

    logic conflict;
    logic i_grant;
    logic d_grant;
    logic i_rd_grant;
    logic d_rd_grant;
    logic i_wr_grant;
    logic d_wr_grant;
    logic rsp_live;

    // A conflict exists only when both requesters want the same port.
    // A read plus a write can both be served in one cycle.
    // On a conflict, the requester that did not win last time is served.
    always_comb begin
        conflict   = i_req_valid && d_req_valid && (i_req_we == d_req_we);
        i_grant    = !cpu_rst && i_req_valid && (!conflict || last_grant == GRANT_D);
        d_grant    = !cpu_rst && d_req_valid && (!conflict || last_grant == GRANT_I);
        i_rd_grant = i_grant && !i_req_we;
        d_rd_grant = d_grant && !d_req_we;
        i_wr_grant = i_grant && i_req_we;
        d_wr_grant = d_grant && d_req_we;
    end

    assign i_req_ready = i_grant;
    assign d_req_ready = d_grant;

    // Drive the memory port from whichever requester holds each side.
    // The grant logic never gives the same side to both requesters at once.
    // An idle side is driven to zero.
    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wren    = 1'b0;
        if (i_rd_grant) begin
            mem_rd_addr = i_req_addr;
        end else if (d_rd_grant) begin
            mem_rd_addr = d_req_addr;
        end
        if (i_wr_grant) begin
            mem_wren    = 1'b1;
            mem_wr_addr = i_req_addr;
            mem_wr_data = i_req_wdata;
        end else if (d_wr_grant) begin
            mem_wren    = 1'b1;
            mem_wr_addr = d_req_addr;
            mem_wr_data = d_req_wdata;
        end
    end

    // Record who owns the read currently in flight, so that the data
    // arriving next cycle is delivered to that requester.
    // On a conflict the winner is always the requester that was not
    // last_grant, so updating last_grant is a toggle.
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            last_grant <= GRANT_I;
            rd_pending <= 1'b0;
            rd_owner   <= GRANT_I;
        end else begin
            if (conflict) begin
                last_grant <= ~last_grant;
            end
            rd_pending <= i_rd_grant || d_rd_grant;
            rd_owner   <= d_rd_grant ? GRANT_D : GRANT_I;
        end
    end

    // A response still in flight when reset arrives is suppressed right
    // away, not only from the next edge onward.
    // Data is masked to zero whenever the matching valid is low.
    always_comb begin
        rsp_live    = rd_pending && !cpu_rst;
        i_rsp_valid = rsp_live && (rd_owner == GRANT_I);
        d_rsp_valid = rsp_live && (rd_owner == GRANT_D);
        i_rsp_data  = i_rsp_valid ? mem_rd_data : '0;
        d_rsp_data  = d_rsp_valid ? mem_rd_data : '0;
    end

endmodule
